// File: rtl/quant_4x4_stream.sv
`default_nettype none
// ============================================================================
// Module   : quant_4x4_stream
// Purpose  : H.264 forward quantizer for 4x4 residual blocks, 3-stage stallable
//            stream pipeline with per-block nonzero level count.
// Revision : 1.0 - initial release
// ============================================================================
module quant_4x4_stream #(
   parameter int BIT_LENGTH = 15,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIT_LENGTH:0]   in_coeff,
   input  logic [5:0]            qp,
   input  logic                  intra,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_level,
   output logic [3:0]            out_index,
   output logic                  out_last,
   output logic [4:0]            out_nz_count
);

   localparam int c_AW = BIT_LENGTH + 1;
   localparam int c_PW = c_AW + 16;
   localparam logic [c_AW-1:0]      c_ONE      = c_AW'(1);
   localparam logic [c_PW-1:0]      c_MAXP     = (c_PW'(1) << (OUT_WIDTH - 1)) - c_PW'(1);
   localparam logic [c_PW-1:0]      c_MAXN_MAG = c_PW'(1) << (OUT_WIDTH - 1);
   localparam logic [OUT_WIDTH-1:0] c_LZERO    = '0;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [3:0]           r_idx, w_idx_nxt, w_idx_cur;
   logic [5:0]           r_qp, w_qp_in, w_qp_cur, w_qdiv, w_qmod, w_qbits;
   logic                 r_intra, w_intra_cur;
   logic                 w_adv, w_fire, w_cls_a, w_cls_b;
   logic [c_AW-1:0]      w_abs;
   logic [13:0]          w_mf;
   logic [23:0]          w_pow, w_f;

   logic                 r_v1, r_sign1, r_last1;
   logic [c_AW-1:0]      r_abs1;
   logic [13:0]          r_mf1;
   logic [23:0]          r_f1;
   logic [5:0]           r_qb1;
   logic [3:0]           r_idx1;

   logic                 r_v2, r_sign2, r_last2;
   logic [c_PW-1:0]      r_p2, w_p2, w_mag;
   logic [5:0]           r_qb2;
   logic [3:0]           r_idx2;

   logic                 r_v3, r_last, w_nz;
   logic [OUT_WIDTH-1:0] r_level, w_lvl;
   logic [3:0]           r_index;
   logic [4:0]           r_nz, w_nz_sum;

   function automatic logic [13:0] mf_lookup(input logic [5:0] m, input logic a, input logic b);
      logic [13:0] r;
      r = 14'd0;
      case (m)
         6'd0:    r = a ? 14'd13107 : (b ? 14'd5243 : 14'd8066);
         6'd1:    r = a ? 14'd11916 : (b ? 14'd4660 : 14'd7490);
         6'd2:    r = a ? 14'd10082 : (b ? 14'd4194 : 14'd6554);
         6'd3:    r = a ? 14'd9362  : (b ? 14'd3647 : 14'd5825);
         6'd4:    r = a ? 14'd8192  : (b ? 14'd3355 : 14'd5243);
         6'd5:    r = a ? 14'd7282  : (b ? 14'd2893 : 14'd4559);
         default: r = 14'd0;
      endcase
      return r;
   endfunction

   assign w_adv    = !r_v3 || out_ready;
   assign in_ready = w_adv;
   assign w_fire   = in_valid && w_adv;
   assign w_qp_in  = (qp > 6'd51) ? 6'd51 : qp;

   // The first beat of a block uses the live qp/intra; later beats use the latched copy.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_idx_cur   = r_idx;
      w_qp_cur    = r_qp;
      w_intra_cur = r_intra;
      case (r_state)
         S_IDLE: begin
            w_idx_cur   = 4'd0;
            w_qp_cur    = w_qp_in;
            w_intra_cur = intra;
            if (w_fire) begin
               w_state_nxt = S_RUN;
               w_idx_nxt   = 4'd1;
            end
         end
         S_RUN: begin
            if (w_fire) begin
               w_idx_nxt = r_idx + 4'd1;
               if (r_idx == 4'd15) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_idx   <= 4'd0;
         r_qp    <= 6'd0;
         r_intra <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (r_state == S_IDLE && w_fire) begin
            r_qp    <= w_qp_in;
            r_intra <= intra;
         end
      end
   end

   assign w_qdiv  = w_qp_cur / 6'd6;
   assign w_qmod  = w_qp_cur - w_qdiv * 6'd6;
   assign w_qbits = 6'd15 + w_qdiv;
   assign w_pow   = 24'd1 << w_qbits;
   assign w_f     = w_intra_cur ? (w_pow / 24'd3) : (w_pow / 24'd6);
   assign w_cls_a = !w_idx_cur[0] && !w_idx_cur[2];
   assign w_cls_b = w_idx_cur[0] && w_idx_cur[2];
   assign w_mf    = mf_lookup(w_qmod, w_cls_a, w_cls_b);
   // Magnitude kept unsigned so the most negative input stays exact.
   assign w_abs   = in_coeff[BIT_LENGTH] ? (~in_coeff + c_ONE) : in_coeff;

   assign w_p2    = c_PW'(r_abs1) * c_PW'(r_mf1) + c_PW'(r_f1);
   assign w_mag   = r_p2 >> r_qb2;
   assign w_nz    = (w_mag != '0);

   always_comb begin
      w_lvl = c_LZERO;
      if (!r_sign2)
         w_lvl = (w_mag > c_MAXP) ? c_MAXP[OUT_WIDTH-1:0] : w_mag[OUT_WIDTH-1:0];
      else
         w_lvl = (w_mag > c_MAXN_MAG) ? c_MAXN_MAG[OUT_WIDTH-1:0]
                                      : (c_LZERO - w_mag[OUT_WIDTH-1:0]);
   end

   assign w_nz_sum = ((r_idx2 == 4'd0) ? 5'd0 : r_nz) + {4'd0, w_nz};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_v1    <= 1'b0;
         r_abs1  <= '0;
         r_sign1 <= 1'b0;
         r_mf1   <= '0;
         r_f1    <= '0;
         r_qb1   <= '0;
         r_idx1  <= '0;
         r_last1 <= 1'b0;
         r_v2    <= 1'b0;
         r_p2    <= '0;
         r_sign2 <= 1'b0;
         r_qb2   <= '0;
         r_idx2  <= '0;
         r_last2 <= 1'b0;
         r_v3    <= 1'b0;
         r_level <= '0;
         r_index <= '0;
         r_last  <= 1'b0;
         r_nz    <= '0;
      end else if (w_adv) begin
         r_v1    <= in_valid;
         r_abs1  <= w_abs;
         r_sign1 <= in_coeff[BIT_LENGTH];
         r_mf1   <= w_mf;
         r_f1    <= w_f;
         r_qb1   <= w_qbits;
         r_idx1  <= w_idx_cur;
         r_last1 <= (w_idx_cur == 4'd15);
         r_v2    <= r_v1;
         r_p2    <= w_p2;
         r_sign2 <= r_sign1;
         r_qb2   <= r_qb1;
         r_idx2  <= r_idx1;
         r_last2 <= r_last1;
         r_v3    <= r_v2;
         if (r_v2) begin
            r_level <= w_lvl;
            r_index <= r_idx2;
            r_last  <= r_last2;
            r_nz    <= w_nz_sum;
         end
      end
   end

   assign out_valid    = r_v3;
   assign out_level    = r_level;
   assign out_index    = r_index;
   assign out_last     = r_last;
   assign out_nz_count = r_nz;

endmodule
`default_nettype wire
